// File: rtl/stream_demux4_pkg.sv
// Shared constants and helpers for the four-way stream demultiplexer.
package stream_demux4_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned CNT_W  = 16;

   // One-hot decode of a channel index.
   function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      return NUM_CH'(1) << sel;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered storage; head is the oldest entry.
module stream_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: rtl/stream_demux4.sv
// Routes one input stream to four independently buffered output channels.
module stream_demux4
   import stream_demux4_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_sel,
   input  logic [DATA_W-1:0] in_data,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [DATA_W-1:0] out_data0,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic [15:0]       cnt0,
   output logic [15:0]       cnt1,
   output logic [15:0]       cnt2,
   output logic [15:0]       cnt3
);

   logic [NUM_CH-1:0] sel_oh, push, pop, full, empty;
   logic [DATA_W-1:0] head [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];

   // Ready depends only on the selected buffer's registered fill state.
   assign sel_oh    = sel_onehot(in_sel);
   assign in_ready  = ~full[in_sel];
   assign push      = {NUM_CH{in_valid & in_ready & ~rst}} & sel_oh;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      stream_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (push[g]),
         .pop     (pop[g]),
         .data_in (in_data),
         .full    (full[g]),
         .empty   (empty[g]),
         .head    (head[g])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i] + CNT_W'(pop[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign out_data0 = head[0];
   assign out_data1 = head[1];
   assign out_data2 = head[2];
   assign out_data3 = head[3];
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];
   assign cnt2      = cnt_q[2];
   assign cnt3      = cnt_q[3];

endmodule
